// File: rtl/hwpe_stream_fence_buffered.sv
// Purpose: joins NB_STREAMS independently buffered input lanes into one lockstep output beat, with a runtime lane mask and perf counters.
// Latency: 1 cycle minimum from a push edge to the pop beat (no push->pop bypass); each lane buffers DEPTH words.
// Backpressure: push_ready_o[i] = lane FIFO not full (state only); a stalled output beat holds valid/data/strb and the mask.
//
// Ports: clk_i/rst_i (async active-high) / clear_i (sync clear); enable_mask_i lane enables;
//        push_valid_i/push_data_i/push_strb_i/push_ready_o per-lane input streams;
//        pop_valid_o/pop_data_o/pop_strb_o/pop_ready_i joined output stream; fire_cnt_o/skew_cnt_o status.

// Generic lane FIFO: stores one {strb,data} word per entry.
// Latency: a word written at edge N is at the head in cycle N+1.
// Backpressure: full_o asserted at DEPTH entries; pushes while full are dropped, no same-cycle bypass.
module hwpe_stream_fence_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt == (AW+1)'(DEPTH));
    assign empty_o = (cnt == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset: the head is only exposed when the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem[wr_ptr] <= din_i;
    end
endmodule

module hwpe_stream_fence_buffered #(
    parameter int unsigned NB_STREAMS = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             clear_i,
    input  logic [NB_STREAMS-1:0]            enable_mask_i,
    input  logic [NB_STREAMS-1:0]            push_valid_i,
    input  logic [NB_STREAMS*DATA_WIDTH-1:0] push_data_i,
    input  logic [NB_STREAMS*DATA_WIDTH/8-1:0] push_strb_i,
    output logic [NB_STREAMS-1:0]            push_ready_o,
    output logic                             pop_valid_o,
    output logic [NB_STREAMS*DATA_WIDTH-1:0] pop_data_o,
    output logic [NB_STREAMS*DATA_WIDTH/8-1:0] pop_strb_o,
    input  logic                             pop_ready_i,
    output logic [CNT_WIDTH-1:0]             fire_cnt_o,
    output logic [CNT_WIDTH-1:0]             skew_cnt_o
);
    localparam int unsigned SW = DATA_WIDTH / 8;
    localparam int unsigned LW = DATA_WIDTH + SW;

    logic [NB_STREAMS-1:0] mask_q;
    logic [NB_STREAMS-1:0] full;
    logic [NB_STREAMS-1:0] empty;
    logic [NB_STREAMS-1:0] lane_pop;
    logic [LW-1:0]         head [NB_STREAMS];
    logic                  fire;
    logic                  any_lane_vld;
    logic                  any_lane_empty;
    logic                  skew;

    assign fire           = pop_valid_o & pop_ready_i;
    assign any_lane_vld   = |(mask_q & ~empty);
    assign any_lane_empty = |(mask_q & empty);
    // Fence passes when at least one lane is enabled and no enabled lane is starved.
    assign pop_valid_o    = (|mask_q) & ~any_lane_empty;
    assign skew           = any_lane_vld & any_lane_empty;
    assign push_ready_o   = ~full;

    for (genvar i = 0; i < NB_STREAMS; i++) begin : g_lane
        // Disabled lanes are never popped, so their contents survive until re-enabled.
        assign lane_pop[i] = fire & mask_q[i];

        hwpe_stream_fence_fifo #(
            .WIDTH (LW),
            .DEPTH (DEPTH)
        ) i_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (clear_i),
            .push_i  (push_valid_i[i]),
            .din_i   ({push_strb_i[i*SW +: SW], push_data_i[i*DATA_WIDTH +: DATA_WIDTH]}),
            .pop_i   (lane_pop[i]),
            .head_o  (head[i]),
            .full_o  (full[i]),
            .empty_o (empty[i])
        );

        // Zero a lane when disabled or empty so idle/reset outputs are clean.
        assign pop_data_o[i*DATA_WIDTH +: DATA_WIDTH] =
            (mask_q[i] & ~empty[i]) ? head[i][DATA_WIDTH-1:0] : '0;
        assign pop_strb_o[i*SW +: SW] =
            (mask_q[i] & ~empty[i]) ? head[i][LW-1:DATA_WIDTH] : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask_q     <= '1;
            fire_cnt_o <= '0;
            skew_cnt_o <= '0;
        end else if (clear_i) begin
            mask_q     <= enable_mask_i;
            fire_cnt_o <= '0;
            skew_cnt_o <= '0;
        end else begin
            // Freeze the mask while a beat is stalled so the offered beat cannot change.
            if (!(pop_valid_o && !pop_ready_i)) mask_q <= enable_mask_i;
            if (fire) fire_cnt_o <= fire_cnt_o + 1'b1;
            if (skew && (skew_cnt_o != '1)) skew_cnt_o <= skew_cnt_o + 1'b1;
        end
    end
endmodule

// File: doc/hwpe_stream_fence_buffered.md
Name: hwpe_stream_fence_buffered

Overview:
Parametrised successor to the stream fence. Joins NB_STREAMS independent input streams into one lockstep output beat. Each input lane has its own DEPTH-entry FIFO, so skewed producers can run ahead without stalling each other. Adds a runtime lane-enable mask, synchronous clear, and fence-performance counters. Sits between multiple streamers/sources and an engine datapath that consumes all operands in the same cycle.

Parameters:
NB_STREAMS, 2, number of input lanes (>=1)
DATA_WIDTH, 32, data bits per lane (multiple of 8)
DEPTH, 4, FIFO entries per lane (power of 2, >=2)
CNT_WIDTH, 8, width of status counters

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is asynchronous and active-high
clear_i  in  1  synchronous clear of FIFOs, counters, mask
enable_mask_i  in  NB_STREAMS  lane enable; 1 = lane participates in fence
push_valid_i  in  NB_STREAMS  per-lane input valid
push_data_i  in  NB_STREAMS*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
push_strb_i  in  NB_STREAMS*DATA_WIDTH/8  per-lane strobes, same packing
push_ready_o  out  NB_STREAMS  per-lane input ready
pop_valid_o  out  1  joined beat valid
pop_data_o  out  NB_STREAMS*DATA_WIDTH  joined data, same lane packing
pop_strb_o  out  NB_STREAMS*DATA_WIDTH/8  joined strobes
pop_ready_i  in  1  joined beat ready
fire_cnt_o  out  CNT_WIDTH  count of pop handshakes
skew_cnt_o  out  CNT_WIDTH  count of cycles the fence was blocked by skew

Behaviour:
- Reset (async, rst_i=1): all FIFOs empty, mask_q = all ones, counters 0. Hence push_ready_o = all ones, pop_valid_o = 0, pop_data_o/pop_strb_o = 0.
- Lane FIFO: push handshake when push_valid_i[i] & push_ready_o[i]. push_ready_o[i] = !full[i]. Depends only on state, never on pop_ready_i. No bypass: a full FIFO refuses a push even in a cycle where it is popped. Strict in-order; data and strb stored together.
- Latency: a word pushed at edge N is visible on pop at cycle N+1 at the earliest. No combinational push->pop path.
- Fence condition:
  - ok = (|mask_q) & AND over i of (!mask_q[i] | !empty[i]).
  - pop_valid_o = ok.
  - Lane i data/strb = FIFO head if mask_q[i], else all zeros.
- Pop handshake (pop_valid_o & pop_ready_i): pops exactly one entry from every enabled lane in the same cycle. Disabled lanes are not popped.
- Disabled lanes keep accepting pushes until full. Their contents are held and resume when the lane is re-enabled.
- Mask: mask_q <= enable_mask_i every cycle except when pop_valid_o & !pop_ready_i. While a beat is stalled, valid, data and strb stay stable (AXI-stream rule).
- mask_q == 0: pop_valid_o stays 0. Pushes are still accepted until full.
- fire_cnt_o: +1 per pop handshake. Wraps modulo 2^CNT_WIDTH.
- skew_cnt_o: +1 in each cycle where at least one enabled FIFO is non-empty and at least one enabled FIFO is empty. Saturates at all ones.
- clear_i: on the next edge, all FIFOs empty, counters 0, mask_q <= enable_mask_i. Overrides any push or pop handshake in the same cycle; that data is discarded.
- Reset mid-transfer: outputs drop to reset values immediately, with no clock edge required.

Test Plan:
- NB=2, DEPTH=4, mask=11. Push 0xA0 on lane0 at cycle 0 and 0xB0 on lane1 at cycle 3, pop_ready=1 -> pop_valid_o=1 in cycle 4 with pop_data_o=0x000000B0_000000A0; fire_cnt=1; skew_cnt=3.
- pop_ready=0, push 5 words per lane back-to-back -> push_ready_o drops after the 4th accepted word per lane and the 5th is held. Then pop_ready=1 -> 4 consecutive beats in push order (fire_cnt=4), followed by the 5th beat.
- mask=01, push 0x1234 (strb 0xF) on lane0 only -> beat with lane0=0x1234, lane1 data=0, lane1 strb=0. A lane1 push is accepted and retained; after switching mask=11 it appears in the next joined beat.
- Both lanes full with pop_valid=1: assert pop_ready_i and push_valid_i together -> pop occurs, push rejected that cycle (push_ready_o=0), occupancy goes 4->3.
- Two entries per lane, pop_valid_o=1: assert clear_i together with a push and pop_ready=1 -> next cycle all FIFOs empty, pop_valid_o=0, fire_cnt=skew_cnt=0, push_ready_o=11.
- CNT_WIDTH=8: perform 256 beats -> fire_cnt_o wraps to 0. Then assert rst_i between edges while pop_valid_o=1 -> pop_valid_o falls before the next clock edge.
